// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, S-box tables and stage FSM encoding
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;

    // Byte 0x00 sits in the top eight bits, byte 0xff in the bottom eight.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return inv ? SBOX_INV[idx +: 8] : SBOX_FWD[idx +: 8];
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// rtl/aes_sbox_byte.sv - one combinational forward/inverse S-box lane
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] inByte,
    input  logic       inDecrypt,
    output logic [7:0] outByte
);

    assign outByte = sbox_lookup(inByte, inDecrypt);

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// rtl/aes_sub_bytes_seq.sv - iterative SubBytes/InvSubBytes, SBOX_LANES bytes per cycle
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 4
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic                   inDecrypt,
    input  logic [AES_BLOCK_W-1:0] inData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [AES_BLOCK_W-1:0] outData
);

    localparam int N     = AES_BYTES / SBOX_LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
              SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
            $error("aes_sub_bytes_seq: SBOX_LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] work_q, work_d;
    logic [AES_BLOCK_W-1:0] out_data_q, out_data_d;
    logic                   mode_q, mode_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready;

    logic [7:0] lane_in  [SBOX_LANES];
    logic [7:0] lane_out [SBOX_LANES];

    always_comb begin
        for (int k = 0; k < SBOX_LANES; k++) begin
            lane_in[k] = work_q[8*(int'(cnt_q)*SBOX_LANES + k) +: 8];
        end
    end

    for (genvar k = 0; k < SBOX_LANES; k++) begin : g_lane
        aes_sbox_byte u_sbox (
            .inByte    (lane_in[k]),
            .inDecrypt (mode_q),
            .outByte   (lane_out[k])
        );
    end

    // DONE forwards downstream readiness so a new block can enter on the handover edge.
    assign in_ready = rstN && ((state_q == ST_IDLE) ||
                               (state_q == ST_DONE && outReady));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (inValid) begin
                    work_d  = inData;
                    mode_d  = inDecrypt;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int k = 0; k < SBOX_LANES; k++) begin
                    work_d[8*(int'(cnt_q)*SBOX_LANES + k) +: 8] = lane_out[k];
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    out_data_d  = work_d;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    if (inValid) begin
                        work_d  = inData;
                        mode_d  = inDecrypt;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_data_q  <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_data_q  <= out_data_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign inReady  = in_ready;
    assign outValid = out_valid_q;
    assign outData  = out_data_q;

endmodule
